// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, ALU codes, FSM states
// and the registered issue bundle handed to the execution stage.
package decode_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_LI  = 4'h8;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [0:0] {
      S_OP  = 1'b0,
      S_IMM = 1'b1
   } state_e;

   typedef struct packed {
      logic [15:0] rd_data;
      logic [15:0] s0;
      logic [1:0]  aluctr;
      logic [15:0] im16;
      logic        s2ctr;
      logic        we;
      logic [3:0]  rdest;
   } issue_t;

   function automatic logic is_alu(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic [1:0] alu_code(input logic [3:0] op);
      logic [1:0] c;
      case (op)
         OP_SUB:  c = ALU_SUB;
         OP_AND:  c = ALU_AND;
         OP_OR:   c = ALU_OR;
         default: c = ALU_ADD;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/regfile_16x16.sv
// 16x16 register file: one synchronous write port, two combinational
// read ports with write-through bypass. Async active-low reset clears all.
module regfile_16x16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we_i,
   input  logic [3:0]  waddr_i,
   input  logic [15:0] wdata_i,
   input  logic [3:0]  raddr_a_i,
   output logic [15:0] rdata_a_o,
   input  logic [3:0]  raddr_b_i,
   output logic [15:0] rdata_b_o
);

   logic [15:0] mem_q [16];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // A write landing this cycle is visible to a same-cycle read.
   assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ?
                      wdata_i : mem_q[raddr_a_i];
   assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ?
                      wdata_i : mem_q[raddr_b_i];

endmodule

// File: rtl/decode_stage.sv
// Decode / register-read stage: accepts instruction words over valid/ready,
// issues one registered bundle per cycle (bubbles for LI first word and RAW).
module decode_stage
   import decode_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [15:0] instr,
   output logic        instr_ready,
   input  logic        wb_we,
   input  logic [3:0]  wb_addr,
   input  logic [15:0] wb_data,
   output logic [15:0] rd_data,
   output logic [15:0] s0,
   output logic [1:0]  aluctr,
   output logic [15:0] im16,
   output logic        s2ctr,
   output logic        we,
   output logic [3:0]  rdest_r,
   output logic        illegal
);

   state_e      state_q, state_d;
   logic [3:0]  rdl_q, rdl_d;
   issue_t      iss_q, iss_d;
   logic        ill_q, ill_d;

   logic [3:0]  op, rd_idx, rs_idx;
   logic [15:0] ra_data, rb_data;
   logic        hazard, acc;
   logic        unused_lo;

   assign op        = instr[15:12];
   assign rd_idx    = instr[11:8];
   assign rs_idx    = instr[7:4];
   assign unused_lo = ^instr[3:0];

   regfile_16x16 u_rf (
      .clk       (clk),
      .rst_n     (rst),
      .we_i      (wb_we),
      .waddr_i   (wb_addr),
      .wdata_i   (wb_data),
      .raddr_a_i (rd_idx),
      .rdata_a_o (ra_data),
      .raddr_b_i (rs_idx),
      .rdata_b_o (rb_data)
   );

   // The producer issued last cycle has not reached write-back yet;
   // holding the consumer one cycle lets it pick the value off the bypass.
   always_comb begin
      hazard = (state_q == S_OP) && is_alu(op) && iss_q.we &&
               ((iss_q.rdest == rd_idx) || (iss_q.rdest == rs_idx));
   end

   assign instr_ready = rst && !hazard;
   assign acc         = instr_valid && instr_ready;

   always_comb begin
      state_d = state_q;
      rdl_d   = rdl_q;
      ill_d   = ill_q;
      iss_d   = '0;
      if (acc) begin
         unique case (state_q)
            S_IMM: begin
               iss_d.im16  = instr;
               iss_d.s2ctr = 1'b1;
               iss_d.we    = 1'b1;
               iss_d.rdest = rdl_q;
               state_d     = S_OP;
            end
            S_OP: begin
               unique case (1'b1)
                  is_alu(op): begin
                     iss_d.rd_data = ra_data;
                     iss_d.s0      = rb_data;
                     iss_d.aluctr  = alu_code(op);
                     iss_d.we      = 1'b1;
                     iss_d.rdest   = rd_idx;
                  end
                  (op == OP_LI): begin
                     state_d = S_IMM;
                     rdl_d   = rd_idx;
                  end
                  (op == OP_NOP): begin
                     state_d = S_OP;
                  end
                  default: begin
                     ill_d = 1'b1;
                  end
               endcase
            end
            default: begin
               state_d = S_OP;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_OP;
         rdl_q   <= '0;
         iss_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdl_q   <= rdl_d;
         iss_q   <= iss_d;
         ill_q   <= ill_d;
      end
   end

   assign rd_data = iss_q.rd_data;
   assign s0      = iss_q.s0;
   assign aluctr  = iss_q.aluctr;
   assign im16    = iss_q.im16;
   assign s2ctr   = iss_q.s2ctr;
   assign we      = iss_q.we;
   assign rdest_r = iss_q.rdest;
   assign illegal = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against an architectural model:
// operands must equal the in-order register state at issue time.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_ready;
   logic        wb_we = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic [15:0] rd_data, s0, im16;
   logic [1:0]  aluctr;
   logic        s2ctr, we, illegal;
   logic [3:0]  rdest_r;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .rd_data     (rd_data),
      .s0          (s0),
      .aluctr      (aluctr),
      .im16        (im16),
      .s2ctr       (s2ctr),
      .we          (we),
      .rdest_r     (rdest_r),
      .illegal     (illegal)
   );

   int nvec = 0;
   int nbad = 0;

   // architectural model
   logic [15:0] arch [16];
   bit          m_imm;
   logic [3:0]  m_rd;
   // expected bundle currently on the outputs
   bit          e_we, e_s2, e_ill;
   logic [1:0]  e_alu;
   logic [15:0] e_a, e_b, e_im;
   logic [3:0]  e_dst;
   // execution-stage result waiting to appear on wb_*
   bit          p_we;
   logic [3:0]  p_addr;
   logic [15:0] p_data;
   bit          last_acc, last_ready;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] alu(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [1:0]  c);
      logic [15:0] r;
      case (c)
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         2'd2:    r = a & b;
         default: r = a | b;
      endcase
      return r;
   endfunction

   function automatic bit op_alu(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd4);
   endfunction

   task automatic check_out(input string t);
      check({t, ".rd_data"}, 32'(rd_data), 32'(e_a));
      check({t, ".s0"},      32'(s0),      32'(e_b));
      check({t, ".aluctr"},  32'(aluctr),  32'(e_alu));
      check({t, ".im16"},    32'(im16),    32'(e_im));
      check({t, ".s2ctr"},   32'(s2ctr),   32'(e_s2));
      check({t, ".we"},      32'(we),      32'(e_we));
      check({t, ".rdest"},   32'(rdest_r), 32'(e_dst));
      check({t, ".illegal"}, 32'(illegal), 32'(e_ill));
   endtask

   task automatic clear_bundle();
      e_we = 0; e_s2 = 0; e_alu = '0;
      e_a = '0; e_b = '0; e_im = '0; e_dst = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) arch[i] = '0;
      m_imm = 0; m_rd = '0; e_ill = 0;
      clear_bundle();
      p_we = 0; p_addr = '0; p_data = '0;
   endtask

   // Called at a negedge; leaves at the next negedge.
   task automatic do_reset();
      model_reset();
      rst = 1'b0;
      instr_valid = 1'b1;
      instr = 16'h1110;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      #1;
      check("rst.ready", 32'(instr_ready), 32'd0);
      check_out("rst");
      @(posedge clk);
      @(negedge clk);
      check("rst.ready2", 32'(instr_ready), 32'd0);
      check_out("rst2");
      rst = 1'b1;
      instr_valid = 1'b0;
   endtask

   // One clock: drive at negedge, predict, check at next negedge.
   task automatic cycle(input bit v, input logic [15:0] w);
      logic [3:0] op, rd, rs;
      bit haz;
      wb_we = p_we; wb_addr = p_addr; wb_data = p_data;
      p_we = e_we;
      p_addr = e_dst;
      p_data = e_s2 ? e_im : alu(e_a, e_b, e_alu);
      instr_valid = v;
      instr = w;
      op = w[15:12]; rd = w[11:8]; rs = w[7:4];
      #1;
      haz = !m_imm && op_alu(op) && e_we &&
            ((e_dst == rd) || (e_dst == rs));
      check("ready", 32'(instr_ready), 32'(!haz));
      last_ready = !haz;
      last_acc = v && !haz;
      clear_bundle();
      if (last_acc) begin
         if (m_imm) begin
            e_we = 1; e_s2 = 1; e_im = w; e_dst = m_rd;
            arch[m_rd] = w;
            m_imm = 0;
         end else if (op_alu(op)) begin
            e_a = arch[rd];
            e_b = arch[rs];
            e_alu = 2'(op - 4'd1);
            e_we = 1;
            e_dst = rd;
            arch[rd] = alu(e_a, e_b, e_alu);
         end else if (op == 4'h8) begin
            m_imm = 1;
            m_rd = rd;
         end else if (op != 4'h0) begin
            e_ill = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_out("out");
   endtask

   task automatic send(input logic [15:0] w);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, w);
         if (last_acc) return;
      end
      check("send.timeout", 32'd0, 32'd1);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // fresh register file reads zero
      for (int i = 0; i < 16; i++)
         send({4'h4, 4'(i), 4'(15 - i), 4'h0});

      // LI r1, 0x1234
      send(16'h8100);
      send(16'h1234);
      check("li.im16", 32'(im16), 32'h1234);
      check("li.rdest", 32'(rdest_r), 32'd1);
      check("li.s2ctr", 32'(s2ctr), 32'd1);

      // dependent ADD r1,r1: one stall then bypassed operands
      cycle(1'b1, 16'h1110);
      check("haz.ready", 32'(last_ready), 32'd0);
      cycle(1'b1, 16'h1110);
      check("haz.rd_data", 32'(rd_data), 32'h1234);
      check("haz.s0", 32'(s0), 32'h1234);
      check("haz.aluctr", 32'(aluctr), 32'd0);

      // LI with a 3-cycle valid gap
      send(16'h8300);
      repeat (3) cycle(1'b0, 16'hFFFF);
      send(16'hBEEF);
      check("gap.im16", 32'(im16), 32'hBEEF);
      check("gap.rdest", 32'(rdest_r), 32'd3);

      // illegal opcode is sticky
      send(16'hF000);
      repeat (3) send(16'h0000);
      check("ill.sticky", 32'(illegal), 32'd1);

      // reset discards a half-received LI
      send(16'h8300);
      do_reset();
      send(16'h2120);
      check("rli.aluctr", 32'(aluctr), 32'd1);
      check("rli.rdest", 32'(rdest_r), 32'd1);
      check("rli.s2ctr", 32'(s2ctr), 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int unsigned r;
         logic [3:0] op;
         r = $urandom_range(0, 199);
         if (r < 120) op = 4'(1 + (r % 4));
         else if (r < 160) op = 4'h8;
         else if (r < 199) op = 4'h0;
         else op = 4'(9 + $urandom_range(0, 6));
         if ($urandom_range(0, 499) == 0) do_reset();
         else cycle($urandom_range(0, 4) != 0,
                    {op, 2'b00, 2'($urandom), 2'b00, 2'($urandom),
                     4'($urandom)});
      end
      // immediates with arbitrary bits
      for (int n = 0; n < 200; n++) begin
         if (!m_imm) send(16'h8000 | 16'(($urandom % 4) << 8));
         send(16'($urandom));
         send({4'h1, 4'($urandom % 4), 4'($urandom % 4), 4'h0});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and register-read stage of the 16-bit pipeline, placed directly upstream of `execution`. It accepts 16-bit instruction words through a valid/ready handshake and reads operands from an internal 16×16 register file. The register file is written back from the `execution` outputs `s2`, `we_r` and `rdest_rr`. The stage issues one registered, cycle-aligned control/operand bundle per cycle to `execution`, inserting bubbles for two-word immediates and read-after-write hazards.

## Interface
Parameters:
- none; widths are fixed by the ISA (16-bit data, 4-bit register index).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  `instr` holds a word.
- `instr`  in  16  instruction or immediate word.
- `instr_ready`  out  1  word accepted on this edge when `instr_valid && instr_ready`.
- `wb_we`  in  1  write-back enable (from `we_r`).
- `wb_addr`  in  4  write-back register (from `rdest_rr`).
- `wb_data`  in  16  write-back data (from `s2`).
- `rd_data`  out  16  operand A = R[rd].
- `s0`  out  16  operand B = R[rs].
- `aluctr`  out  2  ALU op.
- `im16`  out  16  immediate.
- `s2ctr`  out  1  1 = select immediate, 0 = select ALU result.
- `we`  out  1  instruction writes a register.
- `rdest_r`  out  4  destination register.
- `illegal`  out  1  sticky flag: an illegal opcode was seen.

## Operation
- Instruction fields: `[15:12]` opcode, `[11:8]` rd (destination and source A), `[7:4]` rs, `[3:0]` ignored.
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD (`aluctr` 00).
  - 0x2 SUB (01).
  - 0x3 AND (10).
  - 0x4 OR (11).
  - 0x8 LI: two-word instruction; the next accepted word is the 16-bit immediate.
  - All other opcodes are illegal: issue a bubble and set `illegal`, which stays 1 until reset.
- ALU op issue: `rd_data`=R[rd], `s0`=R[rs], `we`=1, `s2ctr`=0, `rdest_r`=rd, `im16`=0.
- LI issue: `im16`=immediate word, `s2ctr`=1, `we`=1, `rdest_r`=rd, `rd_data`=`s0`=0, `aluctr`=00.
- Bubble (NOP, LI first word, stall, no handshake, illegal opcode): all outputs 0 except `illegal`.
- FSM, two states:
  - S_OP: decode. An LI word moves to S_IMM and latches rd. Every other word stays in S_OP.
  - S_IMM: the next accepted word is the immediate; issue LI and return to S_OP. Absent `instr_valid`, hold S_IMM and issue bubbles.
- Hazard stall (S_OP only, ALU ops only): if the currently registered `we`=1 and `rdest_r` equals rd or rs, then `instr_ready`=0 for exactly one cycle and a bubble is issued. NOP, LI and illegal words never stall.
- `instr_ready` = `rst` high AND NOT hazard. It is combinational from `instr` and the stage registers.
- Register file:
  - 16 entries, all reset to 0; R0 is an ordinary register.
  - One synchronous write port driven by `wb_*`.
  - Two combinational read ports with write-through bypass: reading x while `wb_we && wb_addr==x` returns `wb_data`.

## Timing
- Issue latency: the word accepted at edge N appears on the outputs after edge N. All outputs are registered.
- Dependent ALU op directly after its producer: one stall cycle. The operand is then taken from the `wb_*` bypass in the same cycle the producer's result is on `s2`. Resulting spacing: producer issue, bubble, consumer issue.
- Dependence two or more issue slots apart: no stall (bypass or register file).
- Simultaneous write-back and read of the same register: read returns the new data.
- Reset assertion, at any time and asynchronously:
  - all outputs 0;
  - register file 0;
  - FSM to S_OP, discarding a half-received LI;
  - `illegal` cleared;
  - `instr_ready`=0 while `rst` is low.
- The first edge after reset release can accept a word.

## Structure
- Package `decode_pkg`:
  - opcode constants `OP_NOP`, `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`, `OP_LI`;
  - `aluctr` codes;
  - FSM state enum {S_OP, S_IMM}.
- Sub-module `regfile_16x16`: 2 read ports with bypass, 1 write port, async active-low reset.
- Top level holds the FSM, hazard detection, decode and the output registers.

## Test plan
- Reset: with `rst` low, all outputs 0 and `instr_ready`=0. After release, reading any register returns 0.
- LI: words 0x8100 then 0x1234 → next cycle `we`=1, `s2ctr`=1, `im16`=0x1234, `rdest_r`=1. With write-back modelled two cycles later, R1=0x1234.
- Hazard: LI r1 immediately followed by 0x1110 (ADD r1,r1):
  - `instr_ready`=0 for one cycle and a bubble is issued;
  - then `rd_data`=`s0`=0x1234 via bypass, `aluctr`=00.
- Illegal: word 0xF000 → bubble; `illegal` rises to 1 and stays 1 through subsequent NOPs.
- S_IMM gap: 0x8300, then `instr_valid` low for 3 cycles, then 0xBEEF → 3 bubbles, then an LI issue with `im16`=0xBEEF, `rdest_r`=3.
- Reset mid-LI: 0x8300 accepted, `rst` pulsed low, then word 0x2120 → decoded as SUB r1,r2 (`aluctr`=01), not as an immediate.
